// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared constants for the data-memory responder slice: the responder FSM
// state encoding, the default storage depth and a byte-lane merge helper
// used by the storage array.
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    // Responder FSM states; the encoding is fixed so other tools and
    // debug views can decode the state register directly.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Default number of 32-bit words held by the data memory.
    localparam int DMEM_DEPTH = 256;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// ---------------------------------------------------------------------------
// dmem_ram_array
// Single-port synchronous RAM of DEPTH 32-bit words with per-byte write
// enables and a registered read port. The read register only updates on an
// enabled cycle, so the last read word stays on rdata until the next access.
//
// Ports:
//   clk    - clock, all storage updates on its rising edge
//   en     - access enable for this cycle
//   we     - per-byte write enables (bit i -> data bits 8i+7..8i)
//   addr   - word index
//   wdata  - store data
//   rdata  - registered word read at addr on the last enabled cycle
//
// Parameters:
//   DEPTH     - number of words (power of two, >= 4)
//   INIT_ZERO - 1: contents start all-zero in simulation; 0: unspecified
// ---------------------------------------------------------------------------
module dmem_ram_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int INIT_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem_word;
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Storage has no reset: contents survive a responder reset.
    generate
        if (INIT_ZERO != 0) begin : g_zero_init
            logic [31:0] mem [DEPTH] = '{default: 32'h0};
            always_ff @(posedge clk) begin
                if (en && (we != 4'h0)) begin
                    mem[addr] <= merge_bytes(mem[addr], wdata, we);
                end
            end
            assign mem_word = mem[addr];
        end else begin : g_no_init
            logic [31:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (en && (we != 4'h0)) begin
                    mem[addr] <= merge_bytes(mem[addr], wdata, we);
                end
            end
            assign mem_word = mem[addr];
        end
    endgenerate

    // Read data is captured before the write lands (read-old on a store).
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem_word;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory responder: accepts one load/store request at a time over a
// valid/ready request channel, performs it against dmem_ram_array and
// returns a response over a valid/ready response channel.
// Acceptance at edge N -> ACCESS during cycle N..N+1 -> response presented
// after edge N+1, so the initiator first samples rsp_valid at edge N+2.
//
// Ports:
//   clk, resetn           - clock; asynchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only while IDLE)
//   req_write             - 1 = store, 0 = load
//   req_addr              - byte address
//   req_wdata, req_be     - store data and byte enables
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata             - load data; 0 for stores and rejected requests
//   rsp_err               - request rejected (out of range / misaligned)
//
// Build option:
//   DMEM_ALIGN_CHECK_EN - when defined, a byte address with nonzero low two
//                         bits is rejected; otherwise those bits are ignored.
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic          write_q, write_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          err_q, err_d;

    logic          req_bad;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;

    // The reject decision is taken from the live address at acceptance and
    // latched, so ACCESS only needs the word index.
`ifdef DMEM_ALIGN_CHECK_EN
    assign req_bad = (req_addr[31:2] >= 30'(DEPTH)) || (req_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[1:0];
    assign req_bad = (req_addr[31:2] >= 30'(DEPTH));
`endif

    // Next-state and output decode. req_ready comes from state alone so it
    // never depends combinationally on req_valid.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'h0;
        ram_en    = 1'b0;
        ram_we    = 4'h0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = req_bad;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // A rejected request never touches the array.
                ram_en  = !err_q;
                ram_we  = write_q ? be_q : 4'h0;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && !write_q) begin
                    rsp_rdata = ram_rdata;
                end
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    dmem_ram_array #(
        .DEPTH     (DEPTH),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder at default parameters (256 words).
// A transaction-level model tracks each outstanding request by the number
// of edges since acceptance and a word array holding the expected memory;
// a compare process checks the DUT against it on every falling edge, and
// the directed sequence pins the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks;
    int errors;

    dmem_responder u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // ---------------- transaction model ----------------
    logic [31:0] model_mem [DEPTH];
    logic        model_clear;
    logic        compare_en;
    logic        m_busy;
    logic        m_done_access;
    logic        m_write;
    logic        m_err;
    logic [7:0]  m_idx;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic        exp_valid;

    function automatic logic [31:0] laneWrite(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0] be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

    function automatic logic isRejected(input logic [31:0] addr);
        logic bad;
        bad = (addr >= 32'(4 * DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) bad = 1'b1;
`endif
        return bad;
    endfunction

    // A request is outstanding from acceptance until its response handshake;
    // the store lands on the first edge after acceptance, and the response
    // is visible from then on.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy        <= 1'b0;
            m_done_access <= 1'b0;
            if (model_clear) begin
                for (int i = 0; i < DEPTH; i++) model_mem[i] <= 32'h0;
            end
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy        <= 1'b1;
                m_done_access <= 1'b0;
                m_write       <= req_write;
                m_idx         <= req_addr[9:2];
                m_wdata       <= req_wdata;
                m_be          <= req_be;
                m_err         <= isRejected(req_addr);
            end
        end else if (!m_done_access) begin
            m_done_access <= 1'b1;
            m_rdata       <= (m_err || m_write) ? 32'h0 : model_mem[m_idx];
            if (!m_err && m_write) begin
                model_mem[m_idx] <= laneWrite(model_mem[m_idx], m_wdata, m_be);
            end
        end else if (rsp_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            exp_valid = m_busy && m_done_access;
            checkOutput("cmp_req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
            checkOutput("cmp_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                checkOutput("cmp_rsp_rdata", rsp_rdata, m_rdata);
                checkOutput("cmp_rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // One full transaction: present the request, measure edges from
    // acceptance to the first edge that samples rsp_valid high, optionally
    // stall the response for 'hold' cycles, then complete the handshake.
    task automatic applyStimulus(input string tag, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input int hold,
                                 output logic [31:0] rd, output logic er);
        int t;
        int lat;
        rd = 32'h0;
        er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        t = 0;
        while (req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput({tag, "_accept"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd2);
        if (lat < 20) begin
            rd = rsp_rdata;
            er = rsp_err;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checkOutput({tag, "_stall_valid"}, {31'b0, rsp_valid}, 32'd1);
                checkOutput({tag, "_stall_ready"}, {31'b0, req_ready}, 32'd0);
                checkOutput({tag, "_stall_rdata"}, rsp_rdata, rd);
                checkOutput({tag, "_stall_err"}, {31'b0, rsp_err}, {31'b0, er});
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            checkOutput({tag, "_back_idle"}, {31'b0, req_ready}, 32'd1);
            checkOutput({tag, "_valid_drop"}, {31'b0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        checks      = 0;
        errors      = 0;
        compare_en  = 1'b0;
        model_clear = 1'b1;
        resetn      = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_be      = 4'h0;
        rsp_ready   = 1'b0;

        #3;
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn      = 1'b1;
        model_clear = 1'b0;
        compare_en  = 1'b1;

        // Full-word store then load back.
        applyStimulus("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
        checkOutput("st_full_rdata", rd, 32'h0);
        checkOutput("st_full_err", {31'b0, er}, 32'd0);
        applyStimulus("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        checkOutput("ld_full_rdata", rd, 32'hDEADBEEF);
        checkOutput("ld_full_err", {31'b0, er}, 32'd0);

        // Single low byte lane.
        applyStimulus("st_b0", 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, rd, er);
        applyStimulus("ld_b0", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        checkOutput("ld_b0_rdata", rd, 32'hDEADBEAA);

        // No lanes enabled writes nothing.
        applyStimulus("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, er);
        applyStimulus("ld_be0", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        checkOutput("ld_be0_rdata", rd, 32'hDEADBEAA);

        // Lanes 1 and 3 only.
        applyStimulus("st_b13", 1'b1, 32'h10, 32'h11223344, 4'hA, 0, rd, er);
        applyStimulus("ld_b13", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        checkOutput("ld_b13_rdata", rd, 32'h11AD33AA);

        // Out of range: first address past the array, and the very top.
        applyStimulus("st_w0", 1'b1, 32'h0, 32'h12345678, 4'hF, 0, rd, er);
        applyStimulus("ld_oor", 1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er);
        checkOutput("ld_oor_err", {31'b0, er}, 32'd1);
        checkOutput("ld_oor_rdata", rd, 32'h0);
        applyStimulus("st_oor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, er);
        checkOutput("st_oor_err", {31'b0, er}, 32'd1);
        applyStimulus("st_top", 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, 0, rd, er);
        checkOutput("st_top_err", {31'b0, er}, 32'd1);
        applyStimulus("ld_w0", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
        checkOutput("ld_w0_rdata", rd, 32'h12345678);
        checkOutput("ld_w0_err", {31'b0, er}, 32'd0);

        // Last word in range.
        applyStimulus("st_last", 1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF, 0, rd, er);
        applyStimulus("ld_last", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er);
        checkOutput("ld_last_rdata", rd, 32'hA5A55A5A);
        checkOutput("ld_last_err", {31'b0, er}, 32'd0);

        // Response held for five cycles before the initiator takes it.
        applyStimulus("ld_stall", 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
        checkOutput("ld_stall_rdata", rd, 32'h11AD33AA);

        // Misaligned store to byte 0x12 (word 4).
        applyStimulus("st_mis", 1'b1, 32'h12, 32'h55555555, 4'hF, 0, rd, er);
        applyStimulus("ld_mis", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        checkOutput("st_mis_err_on", {31'b0, rsp_err | er}, 32'd1);
        checkOutput("ld_mis_rdata_on", rd, 32'h11AD33AA);
`else
        checkOutput("ld_mis_rdata_off", rd, 32'h55555555);
`endif

        // Reset during ACCESS of a store drops the store.
        applyStimulus("st_old", 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst_acc_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_acc_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_acc_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_acc_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus("ld_old", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        checkOutput("ld_old_rdata", rd, 32'h11223344);

        // Reset while a response is pending discards it.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_rsp_pending", {31'b0, rsp_valid}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_rsp_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus("ld_after", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        checkOutput("ld_after_rdata", rd, 32'h11AD33AA);
`else
        checkOutput("ld_after_rdata", rd, 32'h55555555);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
